// File: rtl/fifo_wr_arb.sv
// fifo_wr_arb: round-robin arbiter packing RF (1-byte) and ALU (2-byte) responses into a FIFO write port
module fifo_wr_arb #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    RF_VLD,
    input  logic [DATA_WIDTH-1:0]   RF_DATA,
    output logic                    RF_ACK,
    input  logic                    ALU_VLD,
    input  logic [2*DATA_WIDTH-1:0] ALU_DATA,
    output logic                    ALU_ACK,
    input  logic                    WFULL,
    output logic                    WINC,
    output logic [DATA_WIDTH-1:0]   WR_DATA,
    output logic                    BUSY
);
    localparam int W = DATA_WIDTH;

    typedef enum logic [1:0] {IDLE, WR_LO, WR_HI} state_t;

    state_t         state_q, state_d;
    logic [2*W-1:0] buf_q, buf_d;
    logic           two_q, two_d;
    logic           last_alu_q, last_alu_d;
    logic           rf_ack_q, rf_ack_d;
    logic           alu_ack_q, alu_ack_d;
    logic           gnt_rf;

    // RF wins unless ALU also requests and RF was the last one served
    assign gnt_rf = RF_VLD && (!ALU_VLD || last_alu_q);
    assign WINC   = (state_q != IDLE) && !WFULL;
    assign BUSY   = (state_q != IDLE);
    assign RF_ACK = rf_ack_q;
    assign ALU_ACK = alu_ack_q;
    assign WR_DATA = (state_q == WR_LO) ? buf_q[W-1:0] :
                     (state_q == WR_HI) ? buf_q[2*W-1:W] : '0;

    // Next-state: capture a packet in IDLE, then advance one byte per accepted write
    always_comb begin
        state_d    = state_q;
        buf_d      = buf_q;
        two_d      = two_q;
        last_alu_d = last_alu_q;
        rf_ack_d   = 1'b0;
        alu_ack_d  = 1'b0;
        case (state_q)
            IDLE: if (RF_VLD || ALU_VLD) begin
                state_d    = WR_LO;
                buf_d      = gnt_rf ? {{W{1'b0}}, RF_DATA} : ALU_DATA;
                two_d      = !gnt_rf;
                last_alu_d = !gnt_rf;
                rf_ack_d   = gnt_rf;
                alu_ack_d  = !gnt_rf;
            end
            WR_LO: if (WINC) state_d = two_q ? WR_HI : IDLE;
            WR_HI: if (WINC) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and registered acknowledges; reset discards any held packet
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q    <= IDLE;
            buf_q      <= '0;
            two_q      <= 1'b0;
            last_alu_q <= 1'b1;
            rf_ack_q   <= 1'b0;
            alu_ack_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            buf_q      <= buf_d;
            two_q      <= two_d;
            last_alu_q <= last_alu_d;
            rf_ack_q   <= rf_ack_d;
            alu_ack_q  <= alu_ack_d;
        end
    end
endmodule

// File: tb/tb_fifo_wr_arb.sv
// tb_fifo_wr_arb: per-cycle vector table plus a mid-packet reset sequence
module tb_fifo_wr_arb;
    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        RF_VLD = 1'b0;
    logic [7:0]  RF_DATA = '0;
    logic        RF_ACK;
    logic        ALU_VLD = 1'b0;
    logic [15:0] ALU_DATA = '0;
    logic        ALU_ACK;
    logic        WFULL = 1'b0;
    logic        WINC;
    logic [7:0]  WR_DATA;
    logic        BUSY;

    int n_cmp = 0;
    int n_bad = 0;

    fifo_wr_arb #(.DATA_WIDTH(8)) dut (
        .CLK(CLK), .RST(RST),
        .RF_VLD(RF_VLD), .RF_DATA(RF_DATA), .RF_ACK(RF_ACK),
        .ALU_VLD(ALU_VLD), .ALU_DATA(ALU_DATA), .ALU_ACK(ALU_ACK),
        .WFULL(WFULL), .WINC(WINC), .WR_DATA(WR_DATA), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        rst;
        logic        rfv;
        logic [7:0]  rfd;
        logic        av;
        logic [15:0] ad;
        logic        wf;
        logic        rack;
        logic        aack;
        logic        winc;
        logic [7:0]  wd;
        logic        busy;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic rst, logic rfv, logic [7:0] rfd, logic av, logic [15:0] ad, logic wf,
                                logic rack, logic aack, logic winc, logic [7:0] wd, logic busy);
        vec_t v;
        v.rst = rst; v.rfv = rfv; v.rfd = rfd; v.av = av; v.ad = ad; v.wf = wf;
        v.rack = rack; v.aack = aack; v.winc = winc; v.wd = wd; v.busy = busy;
        return v;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic rack, input logic aack, input logic winc,
                           input logic [7:0] wd, input logic busy);
        chk({tag, " rf_ack"}, {15'd0, RF_ACK}, {15'd0, rack});
        chk({tag, " alu_ack"}, {15'd0, ALU_ACK}, {15'd0, aack});
        chk({tag, " winc"}, {15'd0, WINC}, {15'd0, winc});
        chk({tag, " wr_data"}, {8'd0, WR_DATA}, {8'd0, wd});
        chk({tag, " busy"}, {15'd0, BUSY}, {15'd0, busy});
    endtask

    initial begin
        //                rst rfv rfd    av  ad        wf   rack aack winc wd     busy
        tbl.push_back(mk(0, 0, 8'h00, 0, 16'h0000, 0,   0, 0, 0, 8'h00, 0)); // reset
        tbl.push_back(mk(1, 1, 8'hA5, 0, 16'h0000, 0,   0, 0, 0, 8'h00, 0)); // RF request, first edge after release
        tbl.push_back(mk(1, 0, 8'h00, 0, 16'h0000, 0,   1, 0, 1, 8'hA5, 1));
        tbl.push_back(mk(1, 0, 8'h00, 0, 16'h0000, 0,   0, 0, 0, 8'h00, 0));
        tbl.push_back(mk(1, 0, 8'h00, 1, 16'h1234, 0,   0, 0, 0, 8'h00, 0)); // ALU request
        tbl.push_back(mk(1, 0, 8'h00, 0, 16'h0000, 0,   0, 1, 1, 8'h34, 1));
        tbl.push_back(mk(1, 0, 8'h00, 0, 16'h0000, 0,   0, 0, 1, 8'h12, 1));
        tbl.push_back(mk(1, 0, 8'h00, 0, 16'h0000, 0,   0, 0, 0, 8'h00, 0));
        tbl.push_back(mk(1, 1, 8'h11, 1, 16'h2233, 0,   0, 0, 0, 8'h00, 0)); // tie, last=ALU -> RF
        tbl.push_back(mk(1, 1, 8'h44, 1, 16'h2233, 0,   1, 0, 1, 8'h11, 1)); // RF presents next item in ACK cycle
        tbl.push_back(mk(1, 1, 8'h44, 1, 16'h2233, 0,   0, 0, 0, 8'h00, 0)); // tie, last=RF -> ALU
        tbl.push_back(mk(1, 1, 8'h44, 1, 16'h5566, 0,   0, 1, 1, 8'h33, 1));
        tbl.push_back(mk(1, 1, 8'h44, 1, 16'h5566, 0,   0, 0, 1, 8'h22, 1));
        tbl.push_back(mk(1, 1, 8'h44, 1, 16'h5566, 0,   0, 0, 0, 8'h00, 0)); // tie -> RF
        tbl.push_back(mk(1, 0, 8'h00, 1, 16'h5566, 0,   1, 0, 1, 8'h44, 1));
        tbl.push_back(mk(1, 0, 8'h00, 1, 16'h5566, 0,   0, 0, 0, 8'h00, 0)); // lone ALU
        tbl.push_back(mk(1, 0, 8'h00, 0, 16'h0000, 0,   0, 1, 1, 8'h66, 1));
        tbl.push_back(mk(1, 0, 8'h00, 0, 16'h0000, 0,   0, 0, 1, 8'h55, 1));
        tbl.push_back(mk(1, 0, 8'h00, 0, 16'h0000, 0,   0, 0, 0, 8'h00, 0));
        tbl.push_back(mk(1, 0, 8'h00, 1, 16'hBEEF, 0,   0, 0, 0, 8'h00, 0)); // ALU with 5-cycle stall
        tbl.push_back(mk(1, 0, 8'h00, 0, 16'h0000, 1,   0, 1, 0, 8'hEF, 1));
        tbl.push_back(mk(1, 0, 8'h00, 0, 16'h0000, 1,   0, 0, 0, 8'hEF, 1));
        tbl.push_back(mk(1, 0, 8'h00, 0, 16'h0000, 1,   0, 0, 0, 8'hEF, 1));
        tbl.push_back(mk(1, 0, 8'h00, 0, 16'h0000, 1,   0, 0, 0, 8'hEF, 1));
        tbl.push_back(mk(1, 0, 8'h00, 0, 16'h0000, 1,   0, 0, 0, 8'hEF, 1));
        tbl.push_back(mk(1, 0, 8'h00, 0, 16'h0000, 0,   0, 0, 1, 8'hEF, 1));
        tbl.push_back(mk(1, 0, 8'h00, 0, 16'h0000, 1,   0, 0, 0, 8'hBE, 1)); // stall on high byte too
        tbl.push_back(mk(1, 0, 8'h00, 0, 16'h0000, 0,   0, 0, 1, 8'hBE, 1));
        tbl.push_back(mk(1, 0, 8'h00, 0, 16'h0000, 0,   0, 0, 0, 8'h00, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge CLK);
            RST = tbl[i].rst; RF_VLD = tbl[i].rfv; RF_DATA = tbl[i].rfd;
            ALU_VLD = tbl[i].av; ALU_DATA = tbl[i].ad; WFULL = tbl[i].wf;
            #1;
            chk_all($sformatf("row%0d", i), tbl[i].rack, tbl[i].aack, tbl[i].winc, tbl[i].wd, tbl[i].busy);
        end

        // Reset while the high byte is pending: packet is dropped
        @(negedge CLK);
        ALU_VLD = 1'b1; ALU_DATA = 16'hCAFE;
        @(negedge CLK);
        ALU_VLD = 1'b0; ALU_DATA = '0;
        #1;
        chk_all("rst_lo", 1'b0, 1'b1, 1'b1, 8'hFE, 1'b1);
        @(negedge CLK);
        #1;
        chk_all("rst_hi", 1'b0, 1'b0, 1'b1, 8'hCA, 1'b1);
        RST = 1'b0;
        #1;
        chk_all("rst_async", 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        @(negedge CLK);
        RST = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            #1;
            chk_all($sformatf("post_rst%0d", i), 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        end
        RF_VLD = 1'b1; RF_DATA = 8'h77; ALU_VLD = 1'b1; ALU_DATA = 16'h8899;
        @(negedge CLK);
        RF_VLD = 1'b0; ALU_VLD = 1'b0;
        #1;
        chk_all("post_rst_tie", 1'b1, 1'b0, 1'b1, 8'h77, 1'b1);
        @(negedge CLK);
        #1;
        chk_all("post_rst_idle", 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
